// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 4-bit write-only sequencer: runs the power-on init ROM, then sends
// handshaked command/data bytes as two timed nibble transfers on the LCD pins.
module lcd_hd44780_ctrl #(
  parameter int T_SETUP   = 2,
  parameter int T_E_HIGH  = 13,
  parameter int T_HOLD    = 27,
  parameter int T_EXEC    = 1080,
  parameter int T_CLEAR   = 44280,
  parameter int T_POWERUP = 405000,
  parameter int T_INIT1   = 110700,
  parameter int T_INIT2   = 2700,
  parameter int CNT_W     = 20
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic       wr_rs,
  input  logic [7:0] wr_data,
  output logic       init_done,
  output logic       busy,
  output logic       lcd_e,
  output logic       lcd_rw,
  output logic       lcd_rs,
  output logic [3:0] lcd_db
);

  typedef enum logic [2:0] {POWERUP, NIB_SETUP, NIB_E, NIB_HOLD, WAIT, IDLE} state_t;

  localparam logic [CNT_W-1:0] LD_SETUP   = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_E_HIGH  = CNT_W'(T_E_HIGH - 1);
  localparam logic [CNT_W-1:0] LD_HOLD    = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] LD_POWERUP = CNT_W'(T_POWERUP - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   wait_q, wait_d;
  logic [2:0]         rom_idx_q, rom_idx_d;
  logic [7:0]         byte_q, byte_d;
  logic               single_q, single_d;
  logic               low_q, low_d;
  logic               init_done_q, init_done_d;
  logic               wr_ready_q, wr_ready_d;
  logic               busy_q, busy_d;
  logic               lcd_e_q, lcd_e_d;
  logic               lcd_rs_q, lcd_rs_d;
  logic [3:0]         lcd_db_q, lcd_db_d;

  logic [2:0]         rom_addr;
  logic               rom_single;
  logic [7:0]         rom_data;
  logic [CNT_W-1:0]   rom_wait;
  logic               accept;

  // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
  function automatic logic [CNT_W-1:0] byte_wait(input logic rs, input logic [7:0] data);
    if (!rs && data[7:2] == 6'd0 && data != 8'd0)
      return CNT_W'(T_CLEAR);
    else
      return CNT_W'(T_EXEC);
  endfunction

  // Init ROM: single nibbles carry their value in the high nibble of the byte.
  always_comb begin
    rom_single = 1'b0;
    rom_data   = 8'h00;
    rom_wait   = CNT_W'(T_EXEC);
    case (rom_addr)
      3'd0: begin rom_single = 1'b1; rom_data = 8'h30; rom_wait = CNT_W'(T_INIT1); end
      3'd1: begin rom_single = 1'b1; rom_data = 8'h30; rom_wait = CNT_W'(T_INIT2); end
      3'd2: begin rom_single = 1'b1; rom_data = 8'h30; end
      3'd3: begin rom_single = 1'b1; rom_data = 8'h20; end
      3'd4: rom_data = 8'h28;
      3'd5: rom_data = 8'h0C;
      3'd6: rom_data = 8'h01;
      3'd7: rom_data = 8'h06;
    endcase
    if (!rom_single)
      rom_wait = byte_wait(1'b0, rom_data);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
    wait_d      = wait_q;
    rom_idx_d   = rom_idx_q;
    byte_d      = byte_q;
    single_d    = single_q;
    low_d       = low_q;
    lcd_rs_d    = lcd_rs_q;
    lcd_db_d    = lcd_db_q;
    accept      = 1'b0;
    rom_addr    = (state_q == POWERUP) ? 3'd0 : rom_idx_q + 3'd1;

    case (state_q)
      POWERUP, WAIT: begin
        if (cnt_q == '0) begin
          if (state_q == WAIT && (init_done_q || rom_idx_q == 3'd7)) begin
            state_d = IDLE;
          end else begin
            state_d   = NIB_SETUP;
            cnt_d     = LD_SETUP;
            rom_idx_d = rom_addr;
            byte_d    = rom_data;
            single_d  = rom_single;
            low_d     = 1'b0;
            wait_d    = rom_wait;
            lcd_rs_d  = 1'b0;
            lcd_db_d  = rom_data[7:4];
          end
        end
      end
      NIB_SETUP: begin
        if (cnt_q == '0) begin
          state_d = NIB_E;
          cnt_d   = LD_E_HIGH;
        end
      end
      NIB_E: begin
        if (cnt_q == '0) begin
          state_d = NIB_HOLD;
          cnt_d   = LD_HOLD;
        end
      end
      NIB_HOLD: begin
        if (cnt_q == '0) begin
          if (!single_q && !low_q) begin
            state_d  = NIB_SETUP;
            cnt_d    = LD_SETUP;
            low_d    = 1'b1;
            lcd_db_d = byte_q[3:0];
          end else begin
            state_d = WAIT;
            cnt_d   = wait_q - CNT_W'(1);
          end
        end
      end
      IDLE: begin
        cnt_d = cnt_q;
        if (wr_valid && wr_ready_q) begin
          accept   = 1'b1;
          state_d  = NIB_SETUP;
          cnt_d    = LD_SETUP;
          byte_d   = wr_data;
          single_d = 1'b0;
          low_d    = 1'b0;
          wait_d   = byte_wait(wr_rs, wr_data);
          lcd_rs_d = wr_rs;
          lcd_db_d = wr_data[7:4];
        end
      end
      default: state_d = POWERUP;
    endcase

    // Ready lags IDLE entry by one cycle so it rises together with init_done.
    lcd_e_d     = (state_d == NIB_E);
    wr_ready_d  = (state_q == IDLE) && !accept;
    busy_d      = !wr_ready_d;
    init_done_d = init_done_q || (state_q == IDLE);
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= POWERUP;
      cnt_q       <= LD_POWERUP;
      wait_q      <= '0;
      rom_idx_q   <= 3'd0;
      byte_q      <= 8'h00;
      single_q    <= 1'b0;
      low_q       <= 1'b0;
      init_done_q <= 1'b0;
      wr_ready_q  <= 1'b0;
      busy_q      <= 1'b1;
      lcd_e_q     <= 1'b0;
      lcd_rs_q    <= 1'b0;
      lcd_db_q    <= 4'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wait_q      <= wait_d;
      rom_idx_q   <= rom_idx_d;
      byte_q      <= byte_d;
      single_q    <= single_d;
      low_q       <= low_d;
      init_done_q <= init_done_d;
      wr_ready_q  <= wr_ready_d;
      busy_q      <= busy_d;
      lcd_e_q     <= lcd_e_d;
      lcd_rs_q    <= lcd_rs_d;
      lcd_db_q    <= lcd_db_d;
    end
  end

  assign wr_ready  = wr_ready_q;
  assign init_done = init_done_q;
  assign busy      = busy_q;
  assign lcd_e     = lcd_e_q;
  assign lcd_rw    = 1'b0;
  assign lcd_rs    = lcd_rs_q;
  assign lcd_db    = lcd_db_q;

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Self-checking bench for lcd_hd44780_ctrl with scaled timing: init sequence,
// randomized byte writes against a pulse/latency model, chained handshakes, reset.
module tb_lcd_hd44780_ctrl;

  localparam int T_SETUP   = 2;
  localparam int T_E_HIGH  = 3;
  localparam int T_HOLD    = 2;
  localparam int T_EXEC    = 5;
  localparam int T_CLEAR   = 9;
  localparam int T_POWERUP = 20;
  localparam int T_INIT1   = 8;
  localparam int T_INIT2   = 4;
  localparam int NIBBLE    = T_SETUP + T_E_HIGH + T_HOLD;

  logic       sys_clk = 1'b0;
  logic       rst_n;
  logic       wr_valid;
  logic       wr_ready;
  logic       wr_rs;
  logic [7:0] wr_data;
  logic       init_done;
  logic       busy;
  logic       lcd_e;
  logic       lcd_rw;
  logic       lcd_rs;
  logic [3:0] lcd_db;

  int checks_total  = 0;
  int checks_passed = 0;

  // Pulse record: {rs/db stable while E high, rs, db, width in cycles}
  logic [13:0] obs_q[$];
  logic [13:0] exp_q[$];
  bit          rw_bad = 1'b0;

  int init_nib[4]  = '{3, 3, 3, 2};
  int init_wait[4] = '{T_INIT1, T_INIT2, T_EXEC, T_EXEC};
  logic [7:0] init_byte[4] = '{8'h28, 8'h0C, 8'h01, 8'h06};

  lcd_hd44780_ctrl #(
    .T_SETUP(T_SETUP), .T_E_HIGH(T_E_HIGH), .T_HOLD(T_HOLD), .T_EXEC(T_EXEC),
    .T_CLEAR(T_CLEAR), .T_POWERUP(T_POWERUP), .T_INIT1(T_INIT1), .T_INIT2(T_INIT2),
    .CNT_W(20)
  ) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_rs(wr_rs), .wr_data(wr_data), .init_done(init_done), .busy(busy),
    .lcd_e(lcd_e), .lcd_rw(lcd_rw), .lcd_rs(lcd_rs), .lcd_db(lcd_db)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic int exp_wait(input logic rs, input logic [7:0] d);
    return (!rs && d >= 8'd1 && d <= 8'd3) ? T_CLEAR : T_EXEC;
  endfunction

  function automatic logic [13:0] mk_pulse(input logic rs, input int nib);
    return {1'b1, rs, 4'(nib), 8'(T_E_HIGH)};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic checkPulses(input string tag);
    checkOutput({tag, "_pulse_count"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0)
      checkOutput({tag, "_pulse"}, obs_q.pop_front(), exp_q.pop_front());
    obs_q.delete();
    exp_q.delete();
  endtask

  // Pulse monitor, sampling on the inactive edge.
  initial begin
    bit         in_pulse = 1'b0;
    bit         stable = 1'b0;
    logic       p_rs = 1'b0;
    logic [3:0] p_db = 4'h0;
    int         width = 0;
    forever begin
      @(negedge sys_clk);
      if (lcd_rw !== 1'b0) rw_bad = 1'b1;
      if (!rst_n) begin
        in_pulse = 1'b0;
      end else if (lcd_e && !in_pulse) begin
        in_pulse = 1'b1; width = 1; stable = 1'b1; p_rs = lcd_rs; p_db = lcd_db;
      end else if (lcd_e) begin
        width++;
        if (lcd_rs !== p_rs || lcd_db !== p_db) stable = 1'b0;
      end else if (in_pulse) begin
        in_pulse = 1'b0;
        obs_q.push_back({stable, p_rs, p_db, 8'(width)});
      end
    end
  end

  // Called just after a negedge with rst_n low; releases reset and follows init.
  task automatic runInit(input string tag);
    int  k = 0;
    int  first_e = 0;
    bit  early = 1'b0;
    int  exp_done = T_POWERUP;
    for (int i = 0; i < 4; i++) begin
      exp_done += NIBBLE + init_wait[i];
      exp_q.push_back(mk_pulse(1'b0, init_nib[i]));
    end
    for (int i = 0; i < 4; i++) begin
      exp_done += 2 * NIBBLE + exp_wait(1'b0, init_byte[i]);
      exp_q.push_back(mk_pulse(1'b0, int'(init_byte[i]) / 16));
      exp_q.push_back(mk_pulse(1'b0, int'(init_byte[i]) % 16));
    end
    exp_done += 1;
    rst_n = 1'b1;
    while (!init_done && k < exp_done + 50) begin
      @(posedge sys_clk);
      k++;
      @(negedge sys_clk);
      if (lcd_e && first_e == 0) first_e = k;
      if (!init_done && wr_ready) early = 1'b1;
    end
    checkOutput({tag, "_first_e_rise"}, first_e, T_POWERUP + T_SETUP);
    checkOutput({tag, "_done_cycle"}, k, exp_done);
    checkOutput({tag, "_ready_with_done"}, wr_ready, 1'b1);
    checkOutput({tag, "_busy_idle"}, busy, 1'b0);
    checkOutput({tag, "_no_early_ready"}, early, 1'b0);
    checkPulses(tag);
  endtask

  // Called just after a negedge; leaves wr_valid high with the next byte when chaining.
  task automatic applyStimulus(input logic rs, input logic [7:0] data, input bit chain,
                               input logic nrs, input logic [7:0] ndata);
    int waited = 0;
    int lat = 0;
    wr_valid = 1'b1;
    wr_rs    = rs;
    wr_data  = data;
    while (!wr_ready && waited < 400) begin
      @(negedge sys_clk);
      waited++;
    end
    if (!wr_ready) begin
      checkOutput("ready_timeout", wr_ready, 1'b1);
      wr_valid = 1'b0;
      return;
    end
    @(posedge sys_clk);
    @(negedge sys_clk);
    if (chain) begin
      wr_rs   = nrs;
      wr_data = ndata;
    end else begin
      wr_valid = 1'b0;
    end
    checkOutput("ready_drop", wr_ready, 1'b0);
    while (!wr_ready && lat < 400) begin
      @(posedge sys_clk);
      lat++;
      @(negedge sys_clk);
    end
    checkOutput($sformatf("latency_rs%0d_%02h", rs, data), lat, 2 * NIBBLE + exp_wait(rs, data) + 1);
    exp_q.push_back(mk_pulse(rs, int'(data) / 16));
    exp_q.push_back(mk_pulse(rs, int'(data) % 16));
    checkPulses($sformatf("byte_rs%0d_%02h", rs, data));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] d;
    logic       r;
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    wr_rs    = 1'b0;
    wr_data  = 8'h00;
    #23;
    checkOutput("reset_lcd_e", lcd_e, 1'b0);
    checkOutput("reset_lcd_rs_db", {lcd_rs, lcd_db}, 5'h0);
    checkOutput("reset_ready", wr_ready, 1'b0);
    checkOutput("reset_init_done", init_done, 1'b0);
    checkOutput("reset_busy", busy, 1'b1);

    // A byte is already presented during init and must wait for the first ready cycle.
    wr_valid = 1'b1;
    wr_rs    = 1'b0;
    wr_data  = 8'h80;
    @(negedge sys_clk);
    runInit("init");
    applyStimulus(1'b0, 8'h80, 1'b0, 1'b0, 8'h00);

    applyStimulus(1'b1, 8'h41, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 8'h01, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 8'h03, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 8'h02, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 8'h04, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 8'h01, 1'b0, 1'b0, 8'h00);

    applyStimulus(1'b0, 8'h30, 1'b1, 1'b0, 8'h31);
    applyStimulus(1'b0, 8'h31, 1'b0, 1'b0, 8'h00);

    for (int i = 0; i < 12; i++) begin
      r = 1'(($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) d = 8'($urandom_range(0, 3));
      else d = 8'($urandom);
      applyStimulus(r, d, 1'b0, 1'b0, 8'h00);
    end

    repeat (20) @(negedge sys_clk);
    checkOutput("no_extra_pulse", obs_q.size(), 0);

    // Reset in the middle of a data byte's E pulse.
    wr_valid = 1'b1;
    wr_rs    = 1'b1;
    wr_data  = 8'h5A;
    @(posedge sys_clk);
    @(negedge sys_clk);
    wr_valid = 1'b0;
    begin
      int n = 0;
      while (!lcd_e && n < 50) begin
        @(negedge sys_clk);
        n++;
      end
    end
    checkOutput("midreset_e_seen", lcd_e, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_lcd_e", lcd_e, 1'b0);
    checkOutput("midreset_init_done", init_done, 1'b0);
    checkOutput("midreset_ready_busy", {wr_ready, busy}, 2'b01);
    checkOutput("midreset_rs_db", {lcd_rs, lcd_db}, 5'h0);
    repeat (3) @(negedge sys_clk);
    obs_q.delete();
    exp_q.delete();
    runInit("reinit");
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0, 8'h00);

    checkOutput("lcd_rw_low", rw_bad, 1'b0);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
